// File: rtl/serial_subtractor16_pkg.sv
// serial_subtractor16_pkg
// Shared definitions for the bit-serial subtractor:
//   WIDTH_DEF : default operand/result width
//   state_e   : 2-bit FSM state encoding (IDLE, SHIFT, DONE)
package serial_subtractor16_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor16_full_subtractor.sv
// full_subtractor
// One-bit subtractor cell: d = x - y - bin.
// Ports:
//   x, y : minuend / subtrahend bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor16.sv
// serial_subtractor16
// Bit-serial subtractor: computes a - b - bin LSB-first, one bit per clock.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   start             : launch request, sampled only in IDLE
//   a, b, bin         : operands and borrow-in, captured on the accepting edge
//   diff, bout        : registered result and final borrow
//   sign, zero,
//   parity, ovf       : registered result flags
//   busy, done        : status; done pulses for one cycle with the result
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | waiting for start, results held
//   ST_SHIFT | one operand bit processed per edge, LSB first
//   ST_DONE  | one-cycle completion, returns to IDLE
module serial_subtractor16
  import serial_subtractor16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             sign,
  output logic             zero,
  output logic             parity,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             sign_q;
  logic             zero_q;
  logic             parity_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic fs_d;
  logic fs_bout;

  full_subtractor u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Difference bits enter at the MSB so the word is aligned after WIDTH shifts.
  assign res_d = {fs_d, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b1;
      parity_q <= 1'b1;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
            res_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          borrow_q <= fs_bout;
          res_q    <= res_d;
          if (cnt_q == LAST_BIT) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            diff_q   <= res_d;
            bout_q   <= fs_bout;
            sign_q   <= res_d[WIDTH-1];
            zero_q   <= (res_d == '0);
            parity_q <= ~^res_d;
            // a_q[0]/b_q[0] hold the operand MSBs while the last bit is processed.
            ovf_q    <= (a_q[0] != b_q[0]) && (res_d[WIDTH-1] != a_q[0]);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign diff   = diff_q;
  assign bout   = bout_q;
  assign sign   = sign_q;
  assign zero   = zero_q;
  assign parity = parity_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_subtractor16.sv
// tb_serial_subtractor16
// Directed bench for serial_subtractor16 with a result scoreboard.
module tb_serial_subtractor16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        bin;
  logic [15:0] diff;
  logic        bout, sign, zero, parity, ovf, busy, done;

  serial_subtractor16 #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .diff   (diff),
    .bout   (bout),
    .sign   (sign),
    .zero   (zero),
    .parity (parity),
    .ovf    (ovf),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] diff;
    logic        bout, sign, zero, parity, ovf;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_diff"},   32'(diff),   32'(e.diff));
        chk({e.name, "_bout"},   32'(bout),   32'(e.bout));
        chk({e.name, "_sign"},   32'(sign),   32'(e.sign));
        chk({e.name, "_zero"},   32'(zero),   32'(e.zero));
        chk({e.name, "_parity"}, 32'(parity), 32'(e.parity));
        chk({e.name, "_ovf"},    32'(ovf),    32'(e.ovf));
        chk({e.name, "_busy"},   32'(busy),   32'd1);
        chk({e.name, "_cycle"},  32'(cyc),    32'(e.cyc));
      end
    end
  end

  // Launch one operation; k returns the cycle number of the accepting edge.
  task automatic issue(input string nm, input logic [15:0] av, input logic [15:0] bv,
                       input logic bi, input logic [15:0] ed, input logic eb,
                       input logic es, input logic ez, input logic ep, input logic eo,
                       input bit push, output int k);
    exp_t e;
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
    chk({nm, "_busy_after_start"}, 32'(busy), 32'd1);
    if (push) begin
      e.diff = ed; e.bout = eb; e.sign = es; e.zero = ez; e.parity = ep; e.ovf = eo;
      e.cyc = k + 16; e.name = nm;
      q.push_back(e);
    end
  endtask

  task automatic drain(input int bound);
    int i;
    i = 0;
    while (q.size() != 0 && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d results pending expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_busy: got busy=%b expected 0", busy);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_diff"},   32'(diff),   32'h0);
    chk({nm, "_bout"},   32'(bout),   32'd0);
    chk({nm, "_sign"},   32'(sign),   32'd0);
    chk({nm, "_zero"},   32'(zero),   32'd1);
    chk({nm, "_parity"}, 32'(parity), 32'd1);
    chk({nm, "_ovf"},    32'(ovf),    32'd0);
    chk({nm, "_busy"},   32'(busy),   32'd0);
    chk({nm, "_done"},   32'(done),   32'd0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    //            name      a         b         bin   diff      bo    sg    zr    pa    ov
    issue("sub3m1",  16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, k);
    drain(40);
    issue("sub1m1",  16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, k);
    drain(40);
    issue("sub5m2b", 16'h0005, 16'h0002, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, k);
    drain(40);
    issue("sub0m1",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, k);
    drain(40);
    issue("sub8000", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, k);
    drain(40);
    issue("sub7fff", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, k);
    drain(40);

    // Start pulse and operand changes mid-operation must be ignored.
    issue("ignore",  16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, k);
    while (cyc < k + 5) @(negedge clk);
    a = 16'h1234; b = 16'h0034; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hFFFF; b = 16'h0000;
    drain(40);
    repeat (20) @(negedge clk);

    // start held high: second operation accepted on the edge after DONE.
    @(negedge clk);
    a = 16'h0000; b = 16'h0000; bin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    begin
      exp_t e;
      e.diff = 16'hFFFF; e.bout = 1'b1; e.sign = 1'b1; e.zero = 1'b0; e.parity = 1'b1;
      e.ovf = 1'b0; e.cyc = k + 16; e.name = "b2b_first";
      q.push_back(e);
      while (cyc < k + 16) @(negedge clk);
      a = 16'h0005; b = 16'h0002; bin = 1'b1;
      e.diff = 16'h0002; e.bout = 1'b0; e.sign = 1'b0; e.zero = 1'b0; e.parity = 1'b0;
      e.ovf = 1'b0; e.cyc = k + 18 + 16; e.name = "b2b_second";
      q.push_back(e);
      while (cyc < k + 19) @(negedge clk);
      start = 1'b0;
    end
    drain(60);

    // Reset mid-operation aborts without a done pulse.
    issue("abort",   16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, k);
    while (cyc < k + 8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue("postrst", 16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, k);
    drain(40);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/serial_subtractor16.md
SERIAL_SUBTRACTOR16 -- requirements
Module: serial_subtractor16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand/result width in bits.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have ports a, b  input  WIDTH  minuend and subtrahend, captured on the accepting edge.
REQ-006 The block SHALL have port bin  input  1  borrow-in, captured with a and b.
REQ-007 The block SHALL have port diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-008 The block SHALL have port bout  output  1  borrow-out: 1 when unsigned a < b + bin.
REQ-009 The block SHALL have ports sign, zero, parity, ovf  output  1 each  result flags.
REQ-010 The block SHALL have ports busy and done  output  1 each  status and completion pulse.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-012 In IDLE with start=1 on an edge, the block SHALL capture a, b, bin, clear the bit counter, and enter SHIFT.
REQ-013 In SHIFT, each edge SHALL process one bit LSB-first: diff bit = a_i ^ b_i ^ borrow; new borrow = (~a_i & b_i) | (~(a_i ^ b_i) & borrow).
REQ-014 After the WIDTH-th SHIFT edge (bit WIDTH-1 processed), the FSM SHALL enter DONE; with start sampled at edge N, done is high for exactly the cycle between edges N+WIDTH and N+WIDTH+1.
REQ-015 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-016 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-017 start SHALL be ignored in SHIFT and DONE, with no effect on the operation in flight; start held high in IDLE after DONE SHALL launch a new operation on the next edge.
REQ-018 Changes on a, b, bin while busy SHALL NOT affect the result.
REQ-019 diff, bout and the flags SHALL update only on the edge entering DONE and SHALL hold their values until the next operation reaches DONE.
REQ-020 Flag definitions: sign = diff[WIDTH-1]; zero = (diff == 0); parity = 1 when diff has an even number of ones; ovf = signed overflow, i.e. a[MSB] != b[MSB] and diff[MSB] != a[MSB].
REQ-021 bout SHALL equal the final serial borrow.

Reset
REQ-022 While rst_n=0, the FSM SHALL be IDLE; diff = 0; bout, sign, ovf, busy and done = 0; zero = 1; parity = 1; bit counter and internal borrow = 0.
REQ-023 Reset asserted mid-operation SHALL abort the operation immediately, with no done pulse; the first start after release SHALL run a full WIDTH-cycle operation.

Structure
REQ-024 A shared package SHALL hold the default WIDTH (16) and the FSM state encoding (2-bit: IDLE, SHIFT, DONE).
REQ-025 The per-bit logic SHALL be one sub-module, full_subtractor (inputs x, y, bin; outputs d, bout), instantiated once.
REQ-026 The bit counter SHALL be clog2(WIDTH) bits wide and SHALL stop incrementing on reaching WIDTH-1.

Verification
REQ-027 The bench SHALL cover a=16'h0003, b=16'h0001, bin=0 -> done 16 cycles after start; diff=16'h0002, bout=0, sign=0, zero=0, parity=0, ovf=0.
REQ-028 The bench SHALL cover a=16'h0001, b=16'h0001, bin=0 -> diff=16'h0000, zero=1, parity=1, bout=0; and a=16'h0005, b=16'h0002, bin=1 -> diff=16'h0002.
REQ-029 The bench SHALL cover a=16'h0000, b=16'h0001, bin=0 -> diff=16'hFFFF, bout=1, sign=1, parity=1, ovf=0.
REQ-030 The bench SHALL cover a=16'h8000, b=16'h0001, bin=0 -> diff=16'h7FFF, ovf=1, bout=0, sign=0, parity=0.
REQ-031 The bench SHALL cover start pulsed again at cycle 5 of an operation, with a and b changed -> ignored; the original result appears at the original done cycle; exactly one done pulse.
REQ-032 The bench SHALL cover rst_n low at cycle 8 of an operation -> all outputs at reset values; no done; a fresh operation afterward produces a correct result after WIDTH cycles.
